oserdes_align_ctrl: RTL and testbench

Link-bring-up controller for the OSERDES loopback test. It sequences the OSERDES reset, then sweeps a selectable reference-path delay until the looped-back IOB bitstream matches the reference serializer output. It then monitors the locked link and re-runs the search when errors appear. It sits between the reference serializer / IBUF output and the comparator/status logic, in the CLK domain.

---
 rtl/oserdes_align_ctrl.sv | 174 +++++++++++++++++
 tb/tb_oserdes_align_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/oserdes_align_ctrl.sv
// OSERDES loopback bring-up: resets the serializer, sweeps the reference
// delay until the looped-back stream matches, then monitors the lock.
module oserdes_align_ctrl #(
    parameter int MAX_DELAY     = 31,
    parameter int DLY_W         = 5,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int WINDOW_BITS   = 1024,
    parameter int ERROR_LIMIT   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I_START,
    input  logic             I_DAT_REF,
    input  logic             I_DAT_IOB,
    output logic             O_SER_RST,
    output logic [DLY_W-1:0] O_DELAY,
    output logic             O_BUSY,
    output logic             O_LOCKED,
    output logic             O_FAIL,
    output logic [15:0]      O_ERROR_CNT
);

    localparam int SR_W  = MAX_DELAY + 1;
    localparam int C1    = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CMAX  = (WINDOW_BITS > C1) ? WINDOW_BITS : C1;
    localparam int CNT_W = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SER_RESET,
        S_SETTLE,
        S_MEASURE,
        S_NEXT,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic [15:0]        acc_q, acc_d;
    logic [15:0]        err_q, err_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic               iob_q;
    logic               mis_q, mis_d;

    logic               tap;
    logic [15:0]        win_base;
    logic [15:0]        win_sum;
    logic               win_end;

    // sr_q[i] is the reference delayed by i+1 cycles
    always_comb begin
        sr_d = SR_W'({sr_q, I_DAT_REF});
        tap  = 1'b0;
        for (int i = 0; i <= MAX_DELAY; i++) begin
            if (delay_q == DLY_W'(i)) tap = sr_q[i];
        end
        mis_d = tap ^ iob_q;
    end

    always_comb begin
        win_base = (cnt_q == '0) ? 16'd0 : acc_q;
        win_sum  = (win_base == 16'hFFFF) ? win_base
                                          : win_base + {15'd0, mis_q};
        win_end  = (cnt_q == CNT_W'(WINDOW_BITS - 1));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        delay_d   = delay_q;
        acc_d     = acc_q;
        err_d     = err_q;
        O_SER_RST = 1'b0;
        O_BUSY    = 1'b0;
        O_LOCKED  = 1'b0;
        O_FAIL    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                O_SER_RST = 1'b1;
                cnt_d     = '0;
                if (I_START) state_d = S_SER_RESET;
            end
            S_SER_RESET: begin
                O_SER_RST = 1'b1;
                O_BUSY    = 1'b1;
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                O_BUSY = 1'b1;
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_MEASURE;
                    cnt_d   = '0;
                end
            end
            S_MEASURE: begin
                O_BUSY = 1'b1;
                acc_d  = win_sum;
                if (win_end) begin
                    err_d   = win_sum;
                    cnt_d   = '0;
                    state_d = (win_sum == 16'd0) ? S_LOCKED : S_NEXT;
                end
            end
            S_NEXT: begin
                O_BUSY = 1'b1;
                cnt_d  = '0;
                if (delay_q == DLY_W'(MAX_DELAY)) begin
                    state_d = S_FAIL;
                end else begin
                    delay_d = delay_q + DLY_W'(1);
                    state_d = S_SETTLE;
                end
            end
            S_LOCKED: begin
                O_LOCKED = 1'b1;
                acc_d    = win_sum;
                if (win_end) begin
                    err_d = win_sum;
                    cnt_d = '0;
                end
                // error-driven re-search and restart share one entry path
                if ((win_end && (win_sum > 16'(ERROR_LIMIT))) || I_START) begin
                    state_d = S_SER_RESET;
                    delay_d = '0;
                    cnt_d   = '0;
                end
            end
            S_FAIL: begin
                O_FAIL = 1'b1;
                cnt_d  = '0;
                if (I_START) begin
                    state_d = S_SER_RESET;
                    delay_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            delay_q <= '0;
            acc_q   <= '0;
            err_q   <= '0;
            sr_q    <= '0;
            iob_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            delay_q <= delay_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            sr_q    <= sr_d;
            iob_q   <= I_DAT_IOB;
            mis_q   <= mis_d;
        end
    end

    assign O_DELAY     = delay_q;
    assign O_ERROR_CNT = err_q;

endmodule

// File: tb/tb_oserdes_align_ctrl.sv
// Bench for oserdes_align_ctrl: small-parameter sweep/lock instance plus a
// single-tap long-window instance for counter saturation.
module tb_oserdes_align_ctrl;

    logic        clk;
    logic        rst, rst2;
    logic        start, start2;
    logic        ref_b, iob, iob2;
    logic        ser1, busy1, locked1, fail1;
    logic [2:0]  delay1;
    logic [15:0] err1;
    logic        ser2, busy2, locked2, fail2;
    logic [0:0]  delay2;
    logic [15:0] err2;

    int checks   = 0;
    int failures = 0;

    int          iob_mode = 0;
    int          flip_req = 0;
    int          flip_done = 0;
    logic [15:0] lfsr;
    logic [15:0] hist;

    oserdes_align_ctrl #(
        .MAX_DELAY(7), .DLY_W(3), .RST_CYCLES(4),
        .SETTLE_CYCLES(4), .WINDOW_BITS(64), .ERROR_LIMIT(0)
    ) dut (
        .CLK(clk), .RST(rst), .I_START(start),
        .I_DAT_REF(ref_b), .I_DAT_IOB(iob),
        .O_SER_RST(ser1), .O_DELAY(delay1), .O_BUSY(busy1),
        .O_LOCKED(locked1), .O_FAIL(fail1), .O_ERROR_CNT(err1)
    );

    oserdes_align_ctrl #(
        .MAX_DELAY(0), .DLY_W(1), .RST_CYCLES(4),
        .SETTLE_CYCLES(4), .WINDOW_BITS(70000), .ERROR_LIMIT(0)
    ) dut2 (
        .CLK(clk), .RST(rst2), .I_START(start2),
        .I_DAT_REF(ref_b), .I_DAT_IOB(iob2),
        .O_SER_RST(ser2), .O_DELAY(delay2), .O_BUSY(busy2),
        .O_LOCKED(locked2), .O_FAIL(fail2), .O_ERROR_CNT(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LFSR reference; IOB is the reference delayed 3 cycles
    initial begin
        lfsr  = 16'hACE1;
        hist  = '0;
        ref_b = 1'b0;
        iob   = 1'b0;
        iob2  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            lfsr  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            hist  = {hist[14:0], lfsr[0]};
            ref_b = hist[0];
            iob2  = ~hist[0];
            iob   = (iob_mode != 0) ? 1'b0 : hist[3];
            if (flip_req != flip_done) begin
                iob       = ~iob;
                flip_done = flip_req;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    typedef struct {
        logic       start;
        logic       ser;
        logic       busy;
        logic       locked;
        logic       fail;
        logic [2:0] delay;
    } vec_t;

    vec_t vecs[10];
    int   n;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};

        rst    = 1'b1;
        rst2   = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ser", {31'd0, ser1}, 1);
        chk("rst_outs", {busy1, locked1, fail1, delay1, err1}, 0);
        rst  = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        start2 = 1'b1;

        // start sequence, SER_RESET length, start ignored in SETTLE
        for (int i = 0; i < 10; i++) begin
            start = vecs[i].start;
            @(posedge clk);
            #1 start2 = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {ser1, busy1, locked1, fail1, delay1},
                {vecs[i].ser, vecs[i].busy, vecs[i].locked,
                 vecs[i].fail, vecs[i].delay});
        end
        start = 1'b0;

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 200 && delay1 != 3'(d + 1); i++) @(negedge clk);
            chk($sformatf("step_to_%0d", d + 1), {29'd0, delay1}, d + 1);
            chk($sformatf("err_nz_tap%0d", d), {31'd0, (err1 != 0)}, 1);
        end
        for (int i = 0; i < 200 && !locked1; i++) @(negedge clk);
        chk("lock1", {31'd0, locked1}, 1);
        chk("lock1_delay", {29'd0, delay1}, 3);
        chk("lock1_err", {16'd0, err1}, 0);
        chk("lock1_busy_fail", {busy1, fail1}, 0);

        // single bit error while locked -> re-search
        repeat (10) @(negedge clk);
        flip_req = flip_req + 1;
        for (int i = 0; i < 200 && locked1; i++) @(negedge clk);
        chk("unlock", {31'd0, locked1}, 0);
        chk("unlock_err", {16'd0, err1}, 1);
        chk("unlock_delay", {29'd0, delay1}, 0);
        n = 0;
        for (int i = 0; i < 20 && ser1; i++) begin
            n++;
            @(negedge clk);
        end
        chk("reser_len", n, 4);
        for (int i = 0; i < 600 && !locked1; i++) @(negedge clk);
        chk("relock", {31'd0, locked1}, 1);
        chk("relock_delay", {29'd0, delay1}, 3);
        chk("relock_err", {16'd0, err1}, 0);

        // restart from LOCKED, then RST in MEASURE at tap 2
        pulse_start;
        @(negedge clk);
        chk("restart_lock", {locked1, delay1, ser1, busy1}, 5'b0_000_11);
        for (int i = 0; i < 400 && delay1 != 3'd2; i++) @(negedge clk);
        chk("reach_tap2", {29'd0, delay1}, 2);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {ser1, delay1, busy1, locked1}, 6'b1_000_00);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_hold", {ser1, busy1, locked1, fail1, delay1}, 7'b1_000_000);

        // stuck IOB -> FAIL at last tap
        iob_mode = 1;
        pulse_start;
        for (int i = 0; i < 1000 && !fail1; i++) @(negedge clk);
        chk("fail1", {31'd0, fail1}, 1);
        chk("fail_delay", {29'd0, delay1}, 7);
        chk("fail_lock_busy", {locked1, busy1}, 0);

        // start from FAIL -> new search from tap 0
        pulse_start;
        @(negedge clk);
        chk("fail_restart", {fail1, delay1, ser1, busy1}, 6'b0_000_11);
        iob_mode = 0;
        for (int i = 0; i < 800 && !locked1; i++) @(negedge clk);
        chk("lock3", {31'd0, locked1}, 1);
        chk("lock3_delay", {29'd0, delay1}, 3);

        // inverted data over a 70000-cycle window saturates the count
        for (int i = 0; i < 80000 && !fail2; i++) @(negedge clk);
        chk("sat_fail", {31'd0, fail2}, 1);
        chk("sat_err", {16'd0, err2}, 32'h0000FFFF);
        chk("sat_lock_busy", {locked2, busy2, delay2}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
